// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, mid-bit sampling,
// optional odd/even parity, 1 or 2 checked stop bits, one-cycle done pulse.
module uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic [2:0]           rx_state
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_CLEANUP = 3'd5
  } state_t;

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_rx_prev;
  logic                 r_fall_pend;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_done;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_busy;

  state_t               w_state_nxt;
  logic                 w_rx;
  logic                 w_fall;
  logic                 w_par;
  logic                 w_fall_pend_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [IDX_W-1:0]     w_bit_idx_nxt;
  logic                 w_stop_idx_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [DATA_BITS-1:0] w_rx_data_nxt;
  logic                 w_done_nxt;
  logic                 w_parity_err_nxt;
  logic                 w_frame_err_nxt;

  assign w_rx   = r_sync2;
  assign w_fall = r_rx_prev & ~r_sync2;

  assign rx_data    = r_rx_data;
  assign done       = r_done;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;
  assign rx_state   = r_state;

  // Next-state and datapath decode
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_bit_idx_nxt    = r_bit_idx;
    w_stop_idx_nxt   = r_stop_idx;
    w_shift_nxt      = r_shift;
    w_rx_data_nxt    = r_rx_data;
    w_done_nxt       = 1'b0;
    w_parity_err_nxt = r_parity_err;
    w_frame_err_nxt  = r_frame_err;
    w_fall_pend_nxt  = 1'b0;
    w_par            = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt      = '0;
        w_bit_idx_nxt  = '0;
        w_stop_idx_nxt = 1'b0;
        if (w_fall || r_fall_pend) begin
          w_state_nxt      = S_START;
          w_parity_err_nxt = 1'b0;
          w_frame_err_nxt  = 1'b0;
        end
      end
      S_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rx ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt              = '0;
          w_shift_nxt[r_bit_idx] = w_rx;
          if (r_bit_idx == IDX_LAST) begin
            w_bit_idx_nxt = '0;
            w_state_nxt   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt        = '0;
          w_par            = (^r_shift) ^ w_rx;
          w_parity_err_nxt = (PARITY == 1) ? ~w_par : w_par;
          w_state_nxt      = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          if (!w_rx) w_frame_err_nxt = 1'b1;
          if (r_stop_idx == STOP_LAST) begin
            w_stop_idx_nxt = 1'b0;
            w_state_nxt    = S_CLEANUP;
            w_rx_data_nxt  = r_shift;
            w_done_nxt     = 1'b1;
          end else begin
            w_stop_idx_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_CLEANUP: begin
        // Remember an edge seen here so IDLE can still start on it
        w_fall_pend_nxt = w_fall;
        w_state_nxt     = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, synchroniser and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_fall_pend  <= 1'b0;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_stop_idx   <= 1'b0;
      r_shift      <= '0;
      r_rx_data    <= '0;
      r_done       <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sync1      <= rx;
      r_sync2      <= r_sync1;
      r_rx_prev    <= r_sync2;
      r_fall_pend  <= w_fall_pend_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_stop_idx   <= w_stop_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_rx_data    <= w_rx_data_nxt;
      r_done       <= w_done_nxt;
      r_parity_err <= w_parity_err_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200); legal range 8..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = odd, 2 = even.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame; legal values 1 or 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-008 SHALL have port rx_data, output, DATA_BITS bits: last received payload, LSB first on the line.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse, frame complete.
REQ-010 SHALL have port parity_err, output, 1 bit: parity mismatch for the frame; valid with done.
REQ-011 SHALL have port frame_err, output, 1 bit: a stop bit was sampled low; valid with done.
REQ-012 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-013 SHALL have port rx_state, output, 3 bits: current FSM state encoding.

Function
REQ-014 SHALL pass rx through a two-flop synchroniser; synchroniser flops reset to 1; all sampling uses the synchronised value.
REQ-015 SHALL implement states IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, CLEANUP=5; encodings 6-7 SHALL return to IDLE next cycle.
REQ-016 IDLE: on synchronised falling edge (previous 1, current 0) SHALL enter START, clear the bit counter, and clear parity_err and frame_err.
REQ-017 START: at counter = CLKS_PER_BIT/2 - 1 (integer division), line low SHALL enter DATA with counter cleared; line high SHALL count as a glitch and return to IDLE with no done.
REQ-018 DATA: every CLKS_PER_BIT cycles SHALL sample one bit into shift position index 0..DATA_BITS-1. After the last bit it SHALL enter PARITY if PARITY != 0, else STOP.
REQ-019 PARITY: SHALL sample one bit after CLKS_PER_BIT cycles. parity_err SHALL be set if XOR(data, parity bit) is 0 for odd, or 1 for even.
REQ-020 STOP: SHALL sample STOP_BITS bits, each CLKS_PER_BIT apart. Any low sample SHALL set frame_err. Sampling SHALL continue through all stop bits.
REQ-021 CLEANUP: rx_data SHALL load the assembled word, done SHALL pulse high for exactly one cycle, and the next state SHALL be IDLE.
REQ-022 Latency: done SHALL assert exactly 1 cycle after the final stop-bit mid-point sample.
REQ-023 rx_data, parity_err and frame_err SHALL hold until the next CLEANUP or start edge respectively.
REQ-024 Line held low (break): SHALL report frame_err with done. No new start SHALL be accepted until the synchronised line has been seen high.
REQ-025 A falling edge arriving in CLEANUP SHALL be detected in IDLE on the following cycle; no edge SHALL be lost for back-to-back frames with one stop bit.
REQ-026 The cycle counter SHALL be $clog2(CLKS_PER_BIT) bits wide and wrap to 0 at every sample point.

Reset
REQ-027 rst_n=0 sampled at a clk edge SHALL force IDLE and set rx_data=0, done=0, parity_err=0, frame_err=0, busy=0, rx_state=0, counters=0, synchroniser=1s.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no done pulse. After release, reception SHALL resume only on a fresh falling edge.

Verification (clk 20 ns, CLKS_PER_BIT=434, bit period 8680 ns)
REQ-029 Defaults; send 0x47, 8N1 -> one done pulse, rx_data=0x47, parity_err=0, frame_err=0, rx_state back to 0.
REQ-030 PARITY=2, send 0xA5 with parity bit 0 -> rx_data=0xA5, parity_err=0. Repeat with parity bit 1 -> parity_err=1.
REQ-031 STOP_BITS=2, send 0x3C with second stop bit low -> frame_err=1, rx_data=0x3C, one done pulse.
REQ-032 300 ns low glitch on idle line -> rx_state returns to 0, no done, rx_data unchanged.
REQ-033 Back-to-back 0x00 then 0xFF, no idle gap -> two done pulses, rx_data 0x00 then 0xFF, no errors.
REQ-034 rst_n low for 2 cycles mid-DATA of 0x55, then send 0x12 -> no done for 0x55, single done with rx_data=0x12.
